// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory stage: FSM state encoding and
// default datapath / register-number widths.
package mem_access_unit_pkg;

  localparam int N_DEFAULT    = 32;
  localparam int RW_W_DEFAULT = 5;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } mau_state_t;

endpackage

// File: rtl/mem_access_unit_mem_wb.sv
// MEM/WB pipeline register. Selects between load data and ALU result,
// qualifies the register-file write, and produces the one-cycle
// overflow and misalignment exception pulses.
module mem_wb_reg #(
  parameter int N    = 32,
  parameter int RW_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic            reg_wr,
  input  logic            mem_to_reg,
  input  logic            overflow,
  input  logic            misaligned,
  input  logic [RW_W-1:0] rw,
  input  logic [N-1:0]    alu_out,
  input  logic [N-1:0]    rdata,
  output logic            wb_valid,
  output logic            wb_RegWr,
  output logic [RW_W-1:0] wb_Rw,
  output logic [N-1:0]    wb_busW,
  output logic            ovf_exc,
  output logic            misalign
);

  // Capture the retiring op every cycle; a stalled cycle arrives with valid=0 and becomes a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_RegWr <= 1'b0;
      wb_Rw    <= '0;
      wb_busW  <= '0;
      ovf_exc  <= 1'b0;
      misalign <= 1'b0;
    end else begin
      wb_valid <= valid;
      wb_RegWr <= valid & reg_wr & ~overflow & ~misaligned;
      wb_Rw    <= rw;
      wb_busW  <= mem_to_reg ? rdata : alu_out;
      ovf_exc  <= valid & overflow;
      misalign <= valid & misaligned;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage of the pipelined CPU: EX/MEM register, data-memory
// handshake with upstream stall, branch resolution and MEM/WB result.
// Optional feature macro: MEM_ALIGN_CHECK_EN enables the word-alignment
// check (misaligned accesses are suppressed and flagged on 'misalign').
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int N    = N_DEFAULT,
  parameter int RW_W = RW_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [N-1:0]    newPC,
  input  logic            Zero,
  input  logic            Overflow,
  input  logic [N-1:0]    ALUout,
  input  logic [N-1:0]    BB,
  input  logic [RW_W-1:0] Rw,
  input  logic            MW,
  input  logic            BR,
  input  logic            MR,
  input  logic            RW,
  output logic            stall,
  output logic            pcsrc,
  output logic [N-1:0]    branch_target,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [N-1:0]    dmem_addr,
  output logic [N-1:0]    dmem_wdata,
  input  logic [N-1:0]    dmem_rdata,
  input  logic            dmem_ready,
  output logic            wb_valid,
  output logic            wb_RegWr,
  output logic [RW_W-1:0] wb_Rw,
  output logic [N-1:0]    wb_busW,
  output logic            ovf_exc,
  output logic            misalign
);

  logic            exm_valid;
  logic [N-1:0]    exm_newPC;
  logic            exm_Zero;
  logic            exm_Overflow;
  logic [N-1:0]    exm_ALUout;
  logic [N-1:0]    exm_BB;
  logic [RW_W-1:0] exm_Rw;
  logic            exm_MW;
  logic            exm_BR;
  logic            exm_MR;
  logic            exm_RW;

  logic            memop;
  logic            mis_access;

  mau_state_t      state;
  logic [15:0]     wait_cnt;

  // EX/MEM register: take a new instruction whenever the memory stage is not waiting on dmem
  always_ff @(posedge clk) begin
    if (rst) begin
      exm_valid    <= 1'b0;
      exm_newPC    <= '0;
      exm_Zero     <= 1'b0;
      exm_Overflow <= 1'b0;
      exm_ALUout   <= '0;
      exm_BB       <= '0;
      exm_Rw       <= '0;
      exm_MW       <= 1'b0;
      exm_BR       <= 1'b0;
      exm_MR       <= 1'b0;
      exm_RW       <= 1'b0;
    end else if (!stall) begin
      exm_valid    <= ex_valid;
      exm_newPC    <= newPC;
      exm_Zero     <= Zero;
      exm_Overflow <= Overflow;
      exm_ALUout   <= ALUout;
      exm_BB       <= BB;
      exm_Rw       <= Rw;
      exm_MW       <= MW;
      exm_BR       <= BR;
      exm_MR       <= MR;
      exm_RW       <= RW;
    end
  end

  assign memop = exm_valid & (exm_MW | exm_MR);

`ifdef MEM_ALIGN_CHECK_EN
  // A misaligned access never reaches memory, so it can never stall
  assign mis_access = memop & (exm_ALUout[1:0] != 2'b00);
`else
  assign mis_access = 1'b0;
`endif

  // Memory request is driven straight from EX/MEM so it stays stable while held
  assign dmem_req      = memop & ~mis_access;
  assign dmem_we       = exm_MW;
  assign dmem_addr     = exm_ALUout;
  assign dmem_wdata    = exm_BB;
  assign stall         = dmem_req & ~dmem_ready;
  assign pcsrc         = exm_valid & exm_BR & exm_Zero & ~stall;
  assign branch_target = exm_newPC;

  // Handshake tracker: marks cycles spent waiting on memory and counts them for debug
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN:     if (stall) state <= HOLD;
        HOLD:    if (dmem_ready) state <= RUN;
        default: state <= RUN;
      endcase
      if (state == HOLD) wait_cnt <= wait_cnt + 16'd1;
    end
  end

  mem_wb_reg #(
    .N    (N),
    .RW_W (RW_W)
  ) u_mem_wb (
    .clk        (clk),
    .rst        (rst),
    .valid      (exm_valid & ~stall),
    .reg_wr     (exm_RW),
    .mem_to_reg (exm_MR),
    .overflow   (exm_Overflow),
    .misaligned (mis_access),
    .rw         (exm_Rw),
    .alu_out    (exm_ALUout),
    .rdata      (dmem_rdata),
    .wb_valid   (wb_valid),
    .wb_RegWr   (wb_RegWr),
    .wb_Rw      (wb_Rw),
    .wb_busW    (wb_busW),
    .ovf_exc    (ovf_exc),
    .misalign   (misalign)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit. Writeback results are predicted
// into a scoreboard queue when an instruction is issued and compared by a
// monitor whenever wb_valid is seen; each scenario task also checks the
// handshake, stall, branch and exception outputs inline.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int N    = 32;
  localparam int RW_W = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            ex_valid;
  logic [N-1:0]    newPC;
  logic            Zero;
  logic            Overflow;
  logic [N-1:0]    ALUout;
  logic [N-1:0]    BB;
  logic [RW_W-1:0] Rw;
  logic            MW;
  logic            BR;
  logic            MR;
  logic            RW;
  logic            stall;
  logic            pcsrc;
  logic [N-1:0]    branch_target;
  logic            dmem_req;
  logic            dmem_we;
  logic [N-1:0]    dmem_addr;
  logic [N-1:0]    dmem_wdata;
  logic [N-1:0]    dmem_rdata;
  logic            dmem_ready;
  logic            wb_valid;
  logic            wb_RegWr;
  logic [RW_W-1:0] wb_Rw;
  logic [N-1:0]    wb_busW;
  logic            ovf_exc;
  logic            misalign;

  mem_access_unit #(.N(N), .RW_W(RW_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .newPC         (newPC),
    .Zero          (Zero),
    .Overflow      (Overflow),
    .ALUout        (ALUout),
    .BB            (BB),
    .Rw            (Rw),
    .MW            (MW),
    .BR            (BR),
    .MR            (MR),
    .RW            (RW),
    .stall         (stall),
    .pcsrc         (pcsrc),
    .branch_target (branch_target),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_ready    (dmem_ready),
    .wb_valid      (wb_valid),
    .wb_RegWr      (wb_RegWr),
    .wb_Rw         (wb_Rw),
    .wb_busW       (wb_busW),
    .ovf_exc       (ovf_exc),
    .misalign      (misalign)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RW_W-1:0] rw;
    logic [N-1:0]    busw;
    logic            regwr;
  } wb_exp_t;

  wb_exp_t sb[$];
  int checks = 0;
  int fails  = 0;

  // Scoreboard monitor: every valid writeback must match the oldest prediction
  always @(negedge clk) begin
    wb_exp_t e;
    if (rst === 1'b0) begin
      if (wb_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("[TB] FAIL wb_unexpected: got wb_valid=1 busW=%h, expected no writeback", wb_busW);
        end else begin
          e = sb.pop_front();
          if ({wb_Rw, wb_busW, wb_RegWr} !== {e.rw, e.busw, e.regwr}) begin
            fails++;
            $display("[TB] FAIL wb_result: got Rw=%0d busW=%h RegWr=%b, expected Rw=%0d busW=%h RegWr=%b",
                     wb_Rw, wb_busW, wb_RegWr, e.rw, e.busw, e.regwr);
          end
        end
      end else begin
        checks++;
        if (wb_RegWr !== 1'b0) begin
          fails++;
          $display("[TB] FAIL bubble_regwr: got wb_RegWr=%b with wb_valid=%b, expected 0", wb_RegWr, wb_valid);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [N-1:0] pc, input logic z, input logic ovf,
                          input logic [N-1:0] alu, input logic [N-1:0] bb, input logic [RW_W-1:0] rn,
                          input logic mw, input logic br, input logic mr, input logic rwe);
    ex_valid = v;  newPC = pc;  Zero = z;  Overflow = ovf;
    ALUout = alu;  BB = bb;     Rw = rn;
    MW = mw;       BR = br;     MR = mr;   RW = rwe;
  endtask

  task automatic drive_bubble;
    drive_ex(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive_bubble();
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    tick();
    tick();
    #2;
    checks++;
    if ({stall, pcsrc, dmem_req, dmem_we} !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL reset_ctrl: got stall/pcsrc/req/we=%b%b%b%b, expected 0000", stall, pcsrc, dmem_req, dmem_we);
    end
    checks++;
    if ({wb_valid, wb_RegWr, ovf_exc, misalign} !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL reset_wb_flags: got valid/regwr/ovf/mis=%b%b%b%b, expected 0000", wb_valid, wb_RegWr, ovf_exc, misalign);
    end
    checks++;
    if ({dmem_addr, dmem_wdata, branch_target} !== {3*N{1'b0}}) begin
      fails++;
      $display("[TB] FAIL reset_busses: got addr=%h wdata=%h target=%h, expected all 0", dmem_addr, dmem_wdata, branch_target);
    end
    checks++;
    if ({wb_Rw, wb_busW} !== {(RW_W+N){1'b0}}) begin
      fails++;
      $display("[TB] FAIL reset_wb_data: got Rw=%0d busW=%h, expected 0/0", wb_Rw, wb_busW);
    end
    rst = 1'b0;
  endtask

  task automatic test_alu_op;
    tick();
    drive_ex(1'b1, '0, 1'b0, 1'b0, 32'h0000_0010, '0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    dmem_ready = 1'($urandom_range(0, 1));
    sb.push_back('{rw: 5'd5, busw: 32'h10, regwr: 1'b1});
    tick();
    drive_bubble();
    #2;
    checks++;
    if ({stall, dmem_req} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL alu_no_stall: got stall=%b req=%b, expected 0 0", stall, dmem_req);
    end
    tick();
    #2;
    checks++;
    if (wb_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL alu_latency: got wb_valid=%b two edges after issue, expected 1", wb_valid);
    end
    dmem_ready = 1'b0;
  endtask

  task automatic test_load_wait;
    int req_cycles;
    int stall_cycles;
    req_cycles   = 0;
    stall_cycles = 0;
    tick();
    drive_ex(1'b1, '0, 1'b0, 1'b0, 32'h0000_0100, '0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1);
    dmem_ready = 1'b0;
    sb.push_back('{rw: 5'd7, busw: 32'hDEAD_BEEF, regwr: 1'b1});
    tick();
    drive_ex(1'b1, '0, 1'b0, 1'b0, 32'h0000_0055, '0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    sb.push_back('{rw: 5'd9, busw: 32'h55, regwr: 1'b1});
    for (int w = 0; w < 3; w++) begin
      if (w < 2) begin
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0BAD_0BAD;
      end else begin
        dmem_ready = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
      end
      #2;
      if (dmem_req === 1'b1) req_cycles++;
      if (stall === 1'b1) stall_cycles++;
      checks++;
      if ({dmem_addr, dmem_we} !== {32'h0000_0100, 1'b0}) begin
        fails++;
        $display("[TB] FAIL load_addr: got addr=%h we=%b in wait %0d, expected 00000100 0", dmem_addr, dmem_we, w);
      end
      tick();
    end
    drive_bubble();
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    #2;
    checks++;
    if (req_cycles !== 3) begin
      fails++;
      $display("[TB] FAIL load_req_cycles: got %0d, expected 3", req_cycles);
    end
    checks++;
    if (stall_cycles !== 2) begin
      fails++;
      $display("[TB] FAIL load_stall_cycles: got %0d, expected 2", stall_cycles);
    end
    checks++;
    if (stall !== 1'b0) begin
      fails++;
      $display("[TB] FAIL held_alu_stall: got stall=%b for held ALU op, expected 0", stall);
    end
    tick();
  endtask

  task automatic test_store;
    tick();
    drive_ex(1'b1, '0, 1'b0, 1'b0, 32'h0000_0200, 32'h0000_1234, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    dmem_ready = 1'b1;
    sb.push_back('{rw: 5'd3, busw: 32'h200, regwr: 1'b0});
    tick();
    drive_bubble();
    #2;
    checks++;
    if ({dmem_req, dmem_we, stall, dmem_wdata, dmem_addr} !== {1'b1, 1'b1, 1'b0, 32'h0000_1234, 32'h0000_0200}) begin
      fails++;
      $display("[TB] FAIL store_req: got req=%b we=%b stall=%b wdata=%h addr=%h, expected 1 1 0 00001234 00000200",
               dmem_req, dmem_we, stall, dmem_wdata, dmem_addr);
    end
    tick();
    #2;
    checks++;
    if (dmem_req !== 1'b0) begin
      fails++;
      $display("[TB] FAIL store_one_cycle: got dmem_req=%b after store, expected 0", dmem_req);
    end
    dmem_ready = 1'b0;
  endtask

  task automatic test_mw_mr_both;
    tick();
    drive_ex(1'b1, '0, 1'b0, 1'b0, 32'h0000_0300, 32'h0000_00AA, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1);
    dmem_ready = 1'b1;
    sb.push_back('{rw: 5'd10, busw: 32'h0000_CAFE, regwr: 1'b1});
    tick();
    drive_bubble();
    dmem_rdata = 32'h0000_CAFE;
    #2;
    checks++;
    if ({dmem_req, dmem_we, stall} !== 3'b110) begin
      fails++;
      $display("[TB] FAIL mwmr_store: got req=%b we=%b stall=%b, expected 1 1 0", dmem_req, dmem_we, stall);
    end
    tick();
    dmem_ready = 1'b0;
    dmem_rdata = '0;
  endtask

  task automatic test_branch;
    tick();
    drive_ex(1'b1, 32'h0000_0400, 1'b1, 1'b0, 32'h0000_0008, '0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    sb.push_back('{rw: 5'd0, busw: 32'h8, regwr: 1'b0});
    tick();
    drive_ex(1'b1, 32'h0000_0800, 1'b0, 1'b0, 32'h0000_000C, '0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    sb.push_back('{rw: 5'd0, busw: 32'hC, regwr: 1'b0});
    #2;
    checks++;
    if ({pcsrc, branch_target} !== {1'b1, 32'h0000_0400}) begin
      fails++;
      $display("[TB] FAIL branch_taken: got pcsrc=%b target=%h, expected 1 00000400", pcsrc, branch_target);
    end
    tick();
    drive_bubble();
    #2;
    checks++;
    if ({pcsrc, branch_target} !== {1'b0, 32'h0000_0800}) begin
      fails++;
      $display("[TB] FAIL branch_not_taken: got pcsrc=%b target=%h, expected 0 00000800", pcsrc, branch_target);
    end
    tick();
  endtask

  task automatic test_branch_with_load;
    tick();
    drive_ex(1'b1, 32'h0000_0500, 1'b1, 1'b0, 32'h0000_0104, '0, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    dmem_ready = 1'b0;
    sb.push_back('{rw: 5'd2, busw: 32'h0000_1111, regwr: 1'b0});
    tick();
    drive_bubble();
    #2;
    checks++;
    if ({pcsrc, stall} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL br_load_stalled: got pcsrc=%b stall=%b, expected 0 1", pcsrc, stall);
    end
    tick();
    dmem_ready = 1'b1;
    dmem_rdata = 32'h0000_1111;
    #2;
    checks++;
    if ({pcsrc, stall} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL br_load_final: got pcsrc=%b stall=%b, expected 1 0", pcsrc, stall);
    end
    tick();
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    #2;
    checks++;
    if (pcsrc !== 1'b0) begin
      fails++;
      $display("[TB] FAIL br_load_after: got pcsrc=%b, expected 0", pcsrc);
    end
  endtask

  task automatic test_overflow;
    tick();
    drive_ex(1'b1, '0, 1'b0, 1'b1, 32'h0000_0007, '0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    sb.push_back('{rw: 5'd4, busw: 32'h7, regwr: 1'b0});
    tick();
    drive_bubble();
    #2;
    checks++;
    if (ovf_exc !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ovf_early: got ovf_exc=%b while op in EX/MEM, expected 0", ovf_exc);
    end
    tick();
    #2;
    checks++;
    if (ovf_exc !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ovf_pulse: got ovf_exc=%b, expected 1", ovf_exc);
    end
    tick();
    #2;
    checks++;
    if (ovf_exc !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ovf_one_cycle: got ovf_exc=%b, expected 0", ovf_exc);
    end
  endtask

  task automatic test_reset_in_hold;
    tick();
    drive_ex(1'b1, '0, 1'b0, 1'b0, 32'h0000_0104, '0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b1);
    dmem_ready = 1'b0;
    tick();
    #2;
    checks++;
    if (stall !== 1'b1) begin
      fails++;
      $display("[TB] FAIL hold_stall: got stall=%b, expected 1", stall);
    end
    tick();
    checks++;
    if (dut.state !== HOLD) begin
      fails++;
      $display("[TB] FAIL hold_state: got state=%0d, expected HOLD", dut.state);
    end
    rst = 1'b1;
    tick();
    drive_bubble();
    #2;
    checks++;
    if ({stall, pcsrc, dmem_req, dmem_we, wb_valid, wb_RegWr, ovf_exc, misalign} !== 8'h00) begin
      fails++;
      $display("[TB] FAIL hold_reset_outputs: got stall/pcsrc/req/we/valid/regwr/ovf/mis=%b%b%b%b%b%b%b%b, expected all 0",
               stall, pcsrc, dmem_req, dmem_we, wb_valid, wb_RegWr, ovf_exc, misalign);
    end
    checks++;
    if ({dut.state, dut.wait_cnt, dmem_addr} !== {RUN, 16'd0, 32'd0}) begin
      fails++;
      $display("[TB] FAIL hold_reset_state: got state=%0d cnt=%0d addr=%h, expected RUN 0 0", dut.state, dut.wait_cnt, dmem_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_misalign;
    tick();
    drive_ex(1'b1, '0, 1'b0, 1'b0, 32'h0000_0102, '0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1);
    dmem_rdata = 32'h0000_0077;
`ifdef MEM_ALIGN_CHECK_EN
    dmem_ready = 1'b0;
    sb.push_back('{rw: 5'd6, busw: 32'h77, regwr: 1'b0});
`else
    dmem_ready = 1'b1;
    sb.push_back('{rw: 5'd6, busw: 32'h77, regwr: 1'b1});
`endif
    tick();
    drive_bubble();
    #2;
    checks++;
`ifdef MEM_ALIGN_CHECK_EN
    if ({dmem_req, stall} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL misalign_suppress: got req=%b stall=%b, expected 0 0", dmem_req, stall);
    end
`else
    if ({dmem_req, stall, dmem_addr} !== {1'b1, 1'b0, 32'h0000_0102}) begin
      fails++;
      $display("[TB] FAIL misalign_passthru: got req=%b stall=%b addr=%h, expected 1 0 00000102", dmem_req, stall, dmem_addr);
    end
`endif
    tick();
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    #2;
    checks++;
`ifdef MEM_ALIGN_CHECK_EN
    if (misalign !== 1'b1) begin
      fails++;
      $display("[TB] FAIL misalign_pulse: got misalign=%b, expected 1", misalign);
    end
`else
    if (misalign !== 1'b0) begin
      fails++;
      $display("[TB] FAIL misalign_tied: got misalign=%b, expected 0", misalign);
    end
`endif
    tick();
    #2;
    checks++;
    if (misalign !== 1'b0) begin
      fails++;
      $display("[TB] FAIL misalign_one_cycle: got misalign=%b, expected 0", misalign);
    end
  endtask

  initial begin
    $display("[TB] starting mem_access_unit bench");
    test_reset();
    test_alu_op();
    test_load_wait();
    test_store();
    test_mw_mr_both();
    test_branch();
    test_branch_with_load();
    test_overflow();
    test_reset_in_hold();
    test_misalign();
    tick();
    tick();
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() !== 0) begin
      fails++;
      $display("[TB] FAIL sb_drained: got %0d pending writebacks, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
